uart_tx_fifo_drain: RTL

- UART transmitter that sits directly downstream of the 8-deep byte FIFO in the UART path.
- Pops one byte at a time through the FIFO's read strobe and serialises it onto the `tx` line as 8N1 (optional parity), LSB first.
- Paces each bit with an internal baud counter and drains the FIFO back-to-back while it is non-empty.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx_fifo_drain.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame sizing.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;   // 100 MHz / 115200
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle of each bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tick  = (r_count == LAST);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from an upstream FIFO and sends them LSB first.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
    // frame_done is registered, so it is launched one cycle before the stop bit ends.
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    uart_state_t          r_state, w_state_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_next;
    logic                 r_tx, w_tx_next;
    logic                 r_fifo_rd, w_fifo_rd_next;
    logic                 r_busy, w_busy_next;
    logic                 r_frame_done, w_frame_done_next;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_next;
`endif

    logic                 w_baud_clr;
    logic                 w_tick;
    logic [CNT_W-1:0]     w_count;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_baud_clr),
        .o_tick  (w_tick),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_fifo_rd    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_tx         <= w_tx_next;
            r_fifo_rd    <= w_fifo_rd_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_idx_next    = r_bit_idx;
        w_tx_next         = r_tx;
        w_fifo_rd_next    = 1'b0;
        w_busy_next       = r_busy;
        w_frame_done_next = 1'b0;
        w_baud_clr        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next     = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_baud_clr = 1'b1;
                if (!fifo_empty) begin
                    w_fifo_rd_next = 1'b1;
                    w_busy_next    = 1'b1;
                    w_state_next   = POP;
                end
            end
            POP: begin
                w_baud_clr   = 1'b1;
                w_state_next = LOAD;
            end
            LOAD: begin
                // Counter is held at zero here so START sees a full bit period.
                w_baud_clr     = 1'b1;
                w_shift_next   = fifo_data;
                w_bit_idx_next = '0;
                w_tx_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
                w_parity_next  = ^fifo_data;
`endif
                w_state_next   = START;
            end
            START: begin
                if (w_tick) begin
                    w_tx_next    = r_shift[0];
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_next    = r_parity;
                        w_state_next = PARITY;
`else
                        w_tx_next    = 1'b1;
                        w_state_next = STOP;
`endif
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_tx_next    = 1'b1;
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                w_frame_done_next = (w_count == PRE_LAST);
                if (w_tick) begin
                    // Only decision point for the next frame; fifo_empty is ignored mid-frame.
                    if (!fifo_empty) begin
                        w_fifo_rd_next = 1'b1;
                        w_state_next   = POP;
                    end else begin
                        w_busy_next  = 1'b0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign fifo_rd    = r_fifo_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
